// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: computes result and flags at the input and registers them.
// A main/skid slot pair on the output absorbs one cycle of downstream stall.
module alu_exec_stage #(
   parameter int DW   = 32,
   parameter int TAGW = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_ctrl,
   input  logic [DW-1:0]   op_a,
   input  logic [DW-1:0]   op_b,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   result,
   output logic            zero,
   output logic            ovf,
   output logic            illegal,
   output logic [TAGW-1:0] out_tag
);

   localparam logic [3:0] C_AND = 4'b0000;
   localparam logic [3:0] C_OR  = 4'b0001;
   localparam logic [3:0] C_ADD = 4'b0010;
   localparam logic [3:0] C_SUB = 4'b0110;
   localparam logic [3:0] C_SLT = 4'b0111;
   localparam logic [3:0] C_NOR = 4'b1111;
   localparam logic [3:0] C_LUI = 4'b1110;

   // Slot payload: {result, zero, ovf, illegal, tag}
   localparam int PW = DW + 3 + TAGW;

   logic [DW-1:0] w_sum;
   logic [DW-1:0] w_diff;
   logic          w_add_ovf;
   logic          w_sub_ovf;
   logic [DW-1:0] w_res;
   logic          w_ovf;
   logic          w_ill;
   logic          w_zero;
   logic [PW-1:0] w_pay;
   logic          w_accept;
   logic          w_drain;

   logic          r_main_valid;
   logic          r_skid_valid;
   logic [PW-1:0] r_main_pay;
   logic [PW-1:0] r_skid_pay;

   assign w_sum     = op_a + op_b;
   assign w_diff    = op_a - op_b;
   assign w_add_ovf = (op_a[DW-1] == op_b[DW-1]) && (w_sum[DW-1] != op_a[DW-1]);
   assign w_sub_ovf = (op_a[DW-1] != op_b[DW-1]) && (w_diff[DW-1] != op_a[DW-1]);

   always_comb begin
      w_res = '0;
      w_ovf = 1'b0;
      w_ill = 1'b0;
      case (alu_ctrl)
         C_AND: w_res = op_a & op_b;
         C_OR:  w_res = op_a | op_b;
         C_ADD: begin
            w_res = w_sum;
            w_ovf = w_add_ovf;
         end
         C_SUB: begin
            w_res = w_diff;
            w_ovf = w_sub_ovf;
         end
         // Sign of the true difference; correct even when the subtract wraps.
         C_SLT: w_res = {{(DW-1){1'b0}}, w_diff[DW-1] ^ w_sub_ovf};
         C_NOR: w_res = ~(op_a | op_b);
         C_LUI: w_res = {op_b[15:0], {(DW-16){1'b0}}};
         default: w_ill = 1'b1;
      endcase
   end

   assign w_zero = (w_res == '0);
   assign w_pay  = {w_res, w_zero, w_ovf, w_ill, in_tag};

   assign in_ready = ~r_skid_valid;
   assign w_accept = in_valid && in_ready;
   assign w_drain  = r_main_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_main_pay   <= '0;
         r_skid_pay   <= '0;
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (!r_main_valid || w_drain) begin
         // Main is free this edge: the older skid entry wins over a new op.
         if (r_skid_valid) begin
            r_main_pay   <= r_skid_pay;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
         end else if (w_accept) begin
            r_main_pay   <= w_pay;
            r_main_valid <= 1'b1;
         end else begin
            r_main_valid <= 1'b0;
         end
      end else if (w_accept) begin
         r_skid_pay   <= w_pay;
         r_skid_valid <= 1'b1;
      end
   end

   assign out_valid = r_main_valid;
   assign result    = r_main_pay[PW-1 -: DW];
   assign zero      = r_main_pay[TAGW+2];
   assign ovf       = r_main_pay[TAGW+1];
   assign illegal   = r_main_pay[TAGW];
   assign out_tag   = r_main_pay[TAGW-1:0];

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized and directed bench for alu_exec_stage, scored against a
// two-deep queue model with results computed by wide signed arithmetic.
module tb_alu_exec_stage;

   localparam int DW   = 32;
   localparam int TAGW = 5;
   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;

   logic            clk;
   logic            rst_n;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_ctrl;
   logic [DW-1:0]   op_a;
   logic [DW-1:0]   op_b;
   logic [TAGW-1:0] in_tag;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   result;
   logic            zero;
   logic            ovf;
   logic            illegal;
   logic [TAGW-1:0] out_tag;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        ovf;
      logic        ill;
      logic [4:0]  tag;
   } item_t;

   item_t q[$];
   int n_chk;
   int n_pass;
   int n_out;

   alu_exec_stage #(.DW(DW), .TAGW(TAGW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .op_a      (op_a),
      .op_b      (op_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .ovf       (ovf),
      .illegal   (illegal),
      .out_tag   (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic item_t model(input logic [3:0] c, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] t);
      item_t  it;
      longint sa;
      longint sb;
      longint s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      it.res  = 32'h0;
      it.ovf  = 1'b0;
      it.ill  = 1'b0;
      it.tag  = t;
      case (c)
         4'b0000: it.res = a & b;
         4'b0001: it.res = a | b;
         4'b0010: begin
            s = sa + sb;
            it.res = 32'(s);
            it.ovf = (s > MAXS) || (s < MINS);
         end
         4'b0110: begin
            s = sa - sb;
            it.res = 32'(s);
            it.ovf = (s > MAXS) || (s < MINS);
         end
         4'b0111: it.res = (sa < sb) ? 32'd1 : 32'd0;
         4'b1111: it.res = ~(a | b);
         4'b1110: it.res = b << 16;
         default: it.ill = 1'b1;
      endcase
      it.zero = (it.res == 32'h0);
      return it;
   endfunction

   task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t);
      in_valid = v;
      alu_ctrl = c;
      op_a     = a;
      op_b     = b;
      in_tag   = t;
   endtask

   // One clock: advance the model with the inputs seen at the edge, then score.
   task automatic step();
      logic acc;
      logic drn;
      if (out_valid && out_ready) begin
         n_out++;
         $display("xfer tag=%0d result=%08h zero=%0d ovf=%0d illegal=%0d",
                  out_tag, result, zero, ovf, illegal);
      end
      @(posedge clk);
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      if (flush) q.delete();
      else begin
         if (drn) void'(q.pop_front());
         if (acc) q.push_back(model(alu_ctrl, op_a, op_b, in_tag));
      end
      #1;
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
         chk("result", 64'(result), 64'(q[0].res));
         chk("zero", 64'(zero), 64'(q[0].zero));
         chk("ovf", 64'(ovf), 64'(q[0].ovf));
         chk("illegal", 64'(illegal), 64'(q[0].ill));
         chk("out_tag", 64'(out_tag), 64'(q[0].tag));
      end
   endtask

   function automatic logic [31:0] rand_op();
      logic [31:0] corners [6];
      corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h0000ABCD};
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
      return $urandom();
   endfunction

   initial begin
      logic [3:0] codes [10];
      codes = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hF, 4'hE, 4'h3, 4'h9, 4'h4};
      n_chk = 0;
      n_pass = 0;
      n_out = 0;
      rst_n = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);

      #2;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_flags", 64'({zero, ovf, illegal}), 64'd0);
      chk("rst_tag", 64'(out_tag), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed ALU cases
      drive(1'b1, 4'b0010, 32'h7FFFFFFF, 32'h1, 5'd1); step();
      chk("add_res", 64'(result), 64'h80000000);
      chk("add_ovf", 64'(ovf), 64'd1);
      chk("add_zero", 64'(zero), 64'd0);
      drive(1'b1, 4'b0110, 32'd5, 32'd5, 5'd2); step();
      chk("sub_res", 64'(result), 64'd0);
      chk("sub_zero", 64'(zero), 64'd1);
      chk("sub_ovf", 64'(ovf), 64'd0);
      drive(1'b1, 4'b0111, 32'h80000000, 32'h7FFFFFFF, 5'd3); step();
      chk("slt_res", 64'(result), 64'd1);
      drive(1'b1, 4'b1110, 32'h0, 32'h0000ABCD, 5'd4); step();
      chk("lui_res", 64'(result), 64'hABCD0000);
      drive(1'b1, 4'b1111, 32'h0, 32'h0, 5'd5); step();
      chk("nor_res", 64'(result), 64'hFFFFFFFF);
      drive(1'b1, 4'b0011, 32'h12345678, 32'h1, 5'd6); step();
      chk("ill_flag", 64'(illegal), 64'd1);
      chk("ill_res", 64'(result), 64'd0);
      in_valid = 1'b0; step();

      // Back-pressure: two ops fill the slots, the third waits
      out_ready = 1'b0;
      drive(1'b1, 4'b0010, 32'd1, 32'd1, 5'd1); step();
      chk("bp_ready1", 64'(in_ready), 64'd1);
      drive(1'b1, 4'b0010, 32'd2, 32'd2, 5'd2); step();
      chk("bp_ready2", 64'(in_ready), 64'd0);
      drive(1'b1, 4'b0010, 32'd3, 32'd3, 5'd3); step();
      chk("bp_hold_tag", 64'(out_tag), 64'd1);
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1; step();
      chk("bp_tag2", 64'(out_tag), 64'd2);
      step();
      chk("bp_tag3", 64'(out_tag), 64'd3);
      in_valid = 1'b0; step();
      chk("bp_empty", 64'(out_valid), 64'd0);

      // Full throughput
      n_out = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 4'b0010, rand_op(), rand_op(), 5'(i + 10));
         step();
         chk("thru_ready", 64'(in_ready), 64'd1);
      end
      in_valid = 1'b0; step();
      chk("thru_cnt", 64'(n_out), 64'd8);

      // Flush with both slots full and an op presented
      out_ready = 1'b0;
      drive(1'b1, 4'b0001, 32'hF0, 32'h0F, 5'd20); step();
      drive(1'b1, 4'b0001, 32'hF00, 32'h0F0, 5'd21); step();
      flush = 1'b1;
      drive(1'b1, 4'b0001, 32'h1, 32'h2, 5'd22); step();
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_ready", 64'(in_ready), 64'd1);
      flush = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 4'b0010, 32'd10, 32'd20, 5'd9); step();
      chk("postflush_res", 64'(result), 64'd30);
      chk("postflush_tag", 64'(out_tag), 64'd9);
      in_valid = 1'b0; step();
      chk("postflush_empty", 64'(out_valid), 64'd0);

      // Asynchronous reset between edges
      out_ready = 1'b0;
      drive(1'b1, 4'b1111, 32'h1, 32'h2, 5'd7); step();
      drive(1'b1, 4'b0010, 32'h5, 32'h6, 5'd8); step();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_ready", 64'(in_ready), 64'd1);
      chk("arst_result", 64'(result), 64'd0);
      chk("arst_flags", 64'({zero, ovf, illegal}), 64'd0);
      chk("arst_tag", 64'(out_tag), 64'd0);
      q.delete();
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 4'b0010, 32'd2, 32'd3, 5'd11); step();
      chk("arst_add", 64'(result), 64'd5);
      chk("arst_add_valid", 64'(out_valid), 64'd1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), codes[$urandom_range(0, 9)],
               rand_op(), rand_op(), 5'($urandom()));
         out_ready = 1'($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 19) == 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
